fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream consumer of the byte FIFO. It pops one word whenever the FIFO reports valid data and the serializer is free. It then shifts the word out as an asynchronous serial frame on a single line: start bit, DATA_WIDTH data bits LSB first, optional parity, then stop bit(s). It is the transmit half of the serial link and sits between the FIFO's read side and the chip pin.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO's data width
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
en  in  1  transmit enable; when low, no new word is popped and the current frame completes
fifo_val  in  1  FIFO holds data; connects to the FIFO val output
fifo_data  in  DATA_WIDTH  FIFO head word, valid whenever fifo_val=1
fifo_read  out  1  pop strobe to the FIFO read input; one cycle per word
tx  out  1  serial line output; idles high
busy  out  1  high from the pop cycle until the frame completes
frame_done  out  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, tx=1, busy=0, frame_done=0, bit counter=0, baud counter=0, shift register=0. fifo_read is 0 throughout reset.
- fifo_read is combinational: (state==IDLE or last cycle of the final stop bit) and fifo_val and en and reset_n.
- On the edge where fifo_read=1, fifo_data is captured into the shift register and the parity accumulator is loaded. The FIFO pops on the same edge, so the word is consumed exactly once.
- FSM states and transitions:
  IDLE -> START when fifo_read=1.
  START (tx=0, CLKS_PER_BIT cycles) -> DATA.
  DATA: bit i drives tx for CLKS_PER_BIT cycles, i=0..DATA_WIDTH-1, LSB first. -> PARITY if PARITY_EN=1, otherwise -> STOP.
  PARITY: tx = XOR of the data bits, inverted when PARITY_ODD=1; CLKS_PER_BIT cycles. -> STOP.
  STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Then -> START if fifo_read=1 in the last cycle (back-to-back frames, zero idle gap); otherwise -> IDLE.
- tx is registered, so the first start-bit cycle appears on tx the cycle after the pop edge. Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1, wraps to 0 and advances the bit. Bit counter is $clog2(DATA_WIDTH+1) bits wide.
- busy=1 in every state except IDLE.
- frame_done pulses for exactly one cycle, coincident with the last stop-bit cycle.
- Boundary conditions:
  en falling mid-frame: the current frame completes unchanged; no further pop.
  fifo_val falling mid-frame: no effect on the current frame.
  fifo_val=1 while busy: no pop except in the last stop cycle.
  reset_n asserted mid-frame: tx returns to 1 immediately (asynchronous); the partial frame is abandoned and the word is lost.
  After reset_n deasserts: no pop in the release cycle's combinational path until the next edge.

Decomposition:
- Shared package fifo_pkg: state enum (IDLE, START, DATA, PARITY, STOP), the DEFAULT_DATA_WIDTH constant shared with the FIFO, and the frame-length function.
- One natural sub-module: baud_tick_gen. It is a CLKS_PER_BIT counter with sync clear, producing a bit_end pulse. It is reusable by the future receive block.

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=0; fifo_val=1 with fifo_data=0xA5 for a single word -> exactly one fifo_read pulse. tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). frame_done pulses on cycle 40; busy drops after it.
- PARITY_EN=1, even, data 0xA5 -> parity bit 0 after the data bits. Repeat with PARITY_ODD=1 -> parity bit 1. Frame is 44 cycles.
- Two words 0x00 then 0xFF queued -> two fifo_read pulses exactly 40 cycles apart. tx shows no idle-high gap between the stop bit and the second start bit. Two frame_done pulses.
- fifo_val=0 for 100 cycles -> tx=1, busy=0, fifo_read=0 throughout.
- en low while 0x3C is queued -> no pop. Raise en -> pop on the next cycle. Drop en mid-frame -> the frame completes and the next queued word is not popped.
- reset_n pulsed low in the DATA state at bit 3 -> tx=1 within the same cycle, busy=0. After release with fifo_val=1 -> a fresh frame starts with a new pop.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types and constants for the byte FIFO and its serial
//            transmit consumer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Word width shared between the FIFO and the serial transmitter
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Serial frame sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Total clk cycles occupied by one serial frame
  function automatic int frame_length(input int data_width, input int parity_en,
                                      input int stop_bits, input int clks_per_bit);
    return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : Counts CLKS_PER_BIT clk cycles per serial bit and flags the last
//            cycle of each bit. Synchronous clear restarts the bit period.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  assign bit_end = (r_cnt == c_last);

  // Free-running bit-period counter; clear holds it at zero between frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops words from the byte FIFO and serializes each as an async
//            frame: start bit, data LSB first, optional parity, stop bit(s).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  fifo_val,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int c_bit_cnt_w = $clog2(DATA_WIDTH + 1);
  localparam logic [c_bit_cnt_w-1:0] c_last_data = c_bit_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_bit_cnt_w-1:0] c_last_stop = c_bit_cnt_w'(STOP_BITS - 1);
  localparam logic [c_bit_cnt_w-1:0] c_bit_one   = c_bit_cnt_w'(1);
  localparam logic                   c_parity_odd = (PARITY_ODD != 0);

  tx_state_t               r_state;
  tx_state_t               w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [DATA_WIDTH-1:0]   w_shift_nxt;
  logic [c_bit_cnt_w-1:0]  r_bit_cnt;
  logic [c_bit_cnt_w-1:0]  w_bit_cnt_nxt;
  logic                    r_parity;
  logic                    w_parity_nxt;
  logic                    r_tx;
  logic                    w_tx_nxt;
  logic                    w_bit_end;
  logic                    w_baud_clear;
  logic                    w_last_stop;

  // The bit period restarts on every pop so a new frame is aligned to it
  assign w_baud_clear = (r_state == IDLE) || fifo_read;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_baud_clear),
    .bit_end (w_bit_end)
  );

  assign tx = r_tx;

  // Next-state, pop strobe and frame sequencing
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_parity_nxt  = r_parity;
    w_tx_nxt      = r_tx;

    w_last_stop = (r_state == STOP) && w_bit_end && (r_bit_cnt == c_last_stop);
    frame_done  = w_last_stop;
    busy        = (r_state != IDLE);
    fifo_read   = ((r_state == IDLE) || w_last_stop) && fifo_val && en && reset_n;

    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_last_data) begin
            w_bit_cnt_nxt = '0;
            if (PARITY_EN != 0) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_parity ^ c_parity_odd;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = STOP;
          w_tx_nxt      = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_last_stop) begin
            w_state_nxt   = IDLE;
            w_tx_nxt      = 1'b1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // A pop always launches a fresh frame, including straight out of the last stop cycle
    if (fifo_read) begin
      w_state_nxt   = START;
      w_tx_nxt      = 1'b0;
      w_shift_nxt   = fifo_data;
      w_parity_nxt  = ^fifo_data;
      w_bit_cnt_nxt = '0;
    end
  end

  // State and datapath registers; reset forces the line idle at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_parity  <= w_parity_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB  = 4;
  localparam int DW   = 8;
  localparam int FLEN = (1 + DW + 1) * CPB;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       fifo_val;
  logic [7:0] fifo_data;
  logic       fifo_read, tx, busy, frame_done;

  logic       p_val;
  logic [7:0] p_data;
  logic       pe_read, pe_tx, pe_busy, pe_done;
  logic       po_read, po_tx, po_busy, po_done;

  int checks = 0;
  int errors = 0;

  // model: pending FIFO words, word on the line, cycles left in its frame
  byte unsigned mq[$];
  bit           src_on;
  logic [7:0]   cur_word;
  int           rem;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .fifo_val(fifo_val), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .tx(tx), .busy(busy), .frame_done(frame_done));

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
    .clk(clk), .reset_n(reset_n), .en(en), .fifo_val(p_val), .fifo_data(p_data),
    .fifo_read(pe_read), .tx(pe_tx), .busy(pe_busy), .frame_done(pe_done));

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
    .clk(clk), .reset_n(reset_n), .en(en), .fifo_val(p_val), .fifo_data(p_data),
    .fifo_read(po_read), .tx(po_tx), .busy(po_busy), .frame_done(po_done));

  // Line level of bit slot idx of a frame carrying w
  function automatic logic frame_bit(input logic [7:0] w, input int pe, input int odd, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (pe != 0 && idx == DW + 1) return logic'((($countones(w) % 2) + odd) % 2);
    return 1'b1;
  endfunction

  // Expected {fifo_read, tx, busy, frame_done} for the current cycle
  function automatic logic [3:0] exp_vec();
    logic rd, t, b, d;
    rd = reset_n && en && src_on && (mq.size() > 0) && (rem <= 1);
    t  = (rem > 0) ? frame_bit(cur_word, 0, 0, (FLEN - rem) / CPB) : 1'b1;
    b  = (rem > 0);
    d  = (rem == 1);
    return {rd, t, b, d};
  endfunction

  task automatic drive();
    fifo_val  = src_on && (mq.size() != 0);
    fifo_data = (mq.size() != 0) ? mq[0] : 8'($urandom);
  endtask

  // Cross one rising edge and move the model with it
  task automatic advance();
    logic [3:0] v;
    v = exp_vec();
    @(posedge clk);
    if (v[3]) begin
      cur_word = mq.pop_front();
      rem      = FLEN;
    end else if (rem > 0) begin
      rem--;
    end
    #1;
    drive();
  endtask

  task automatic test_reset();
    logic [3:0] ev;
    reset_n = 1'b0; en = 1'b1; src_on = 1'b1; rem = 0;
    p_val = 1'b0; p_data = 8'h00;
    mq.push_back(8'h11);
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if ({fifo_read, tx, busy, frame_done} !== ev) begin
        errors++;
        $display("FAIL reset cyc %0d rd/tx/busy/done got %b exp %b", c, {fifo_read, tx, busy, frame_done}, ev);
      end
      advance();
    end
    src_on = 1'b0; mq.delete(); drive();
    reset_n = 1'b1;
    advance();
  endtask

  task automatic test_single_word();
    logic [3:0] ev;
    int pops = 0, c_pop = -1, c_done = -1;
    mq.push_back(8'hA5); src_on = 1'b1; drive();
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if ({fifo_read, tx, busy, frame_done} !== ev) begin
        errors++;
        $display("FAIL single cyc %0d rd/tx/busy/done got %b exp %b", c, {fifo_read, tx, busy, frame_done}, ev);
      end
      if (fifo_read === 1'b1) begin pops++; c_pop = c; end
      if (frame_done === 1'b1) c_done = c;
      advance();
    end
    checks++;
    if (pops !== 1) begin errors++; $display("FAIL single pop_count got %0d exp 1", pops); end
    checks++;
    if (c_done - c_pop !== 40) begin errors++; $display("FAIL single done_latency got %0d exp 40", c_done - c_pop); end
  endtask

  task automatic test_parity();
    logic [5:0] got, exp;
    int k;
    p_val = 1'b1; p_data = 8'hA5;
    @(negedge clk);
    checks++;
    if ({pe_read, po_read} !== 2'b11) begin
      errors++; $display("FAIL parity pop got %b exp 11", {pe_read, po_read});
    end
    @(posedge clk); #1;
    p_val = 1'b0; p_data = 8'($urandom);
    for (k = 0; k < 44; k++) begin
      @(negedge clk);
      exp = {frame_bit(8'hA5, 1, 0, k / CPB), (k == 43), 1'b1,
             frame_bit(8'hA5, 1, 1, k / CPB), (k == 43), 1'b1};
      got = {pe_tx, pe_done, pe_busy, po_tx, po_done, po_busy};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL parity cyc %0d even/odd tx/done/busy got %b exp %b", k, got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({pe_tx, pe_busy, po_tx, po_busy} !== 4'b1010) begin
      errors++; $display("FAIL parity after_frame tx/busy got %b exp 1010", {pe_tx, pe_busy, po_tx, po_busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ev;
    int pops = 0, dones = 0, c_pop[2];
    mq.push_back(8'h00); mq.push_back(8'hFF); src_on = 1'b1; drive();
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if ({fifo_read, tx, busy, frame_done} !== ev) begin
        errors++;
        $display("FAIL b2b cyc %0d rd/tx/busy/done got %b exp %b", c, {fifo_read, tx, busy, frame_done}, ev);
      end
      if (fifo_read === 1'b1) begin
        if (pops < 2) c_pop[pops] = c;
        pops++;
      end
      if (frame_done === 1'b1) dones++;
      advance();
    end
    checks++;
    if (pops !== 2) begin errors++; $display("FAIL b2b pop_count got %0d exp 2", pops); end
    checks++;
    if (pops >= 2 && c_pop[1] - c_pop[0] !== 40) begin
      errors++; $display("FAIL b2b pop_spacing got %0d exp 40", c_pop[1] - c_pop[0]);
    end
    checks++;
    if (dones !== 2) begin errors++; $display("FAIL b2b done_count got %0d exp 2", dones); end
  endtask

  task automatic test_idle();
    logic [3:0] ev;
    src_on = 1'b0; drive();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if ({fifo_read, tx, busy, frame_done} !== ev) begin
        errors++;
        $display("FAIL idle cyc %0d rd/tx/busy/done got %b exp %b", c, {fifo_read, tx, busy, frame_done}, ev);
      end
      advance();
    end
  endtask

  task automatic test_enable();
    logic [3:0] ev;
    int pops;
    en = 1'b0; src_on = 1'b1; mq.push_back(8'h3C); drive();
    for (int ph = 0; ph < 4; ph++) begin
      pops = 0;
      for (int c = 0; c < ((ph == 0) ? 10 : (ph == 1) ? 20 : (ph == 2) ? 30 : 45); c++) begin
        @(negedge clk);
        ev = exp_vec();
        checks++;
        if ({fifo_read, tx, busy, frame_done} !== ev) begin
          errors++;
          $display("FAIL enable ph %0d cyc %0d rd/tx/busy/done got %b exp %b", ph, c, {fifo_read, tx, busy, frame_done}, ev);
        end
        if (fifo_read === 1'b1) pops++;
        advance();
      end
      checks++;
      if (pops !== ((ph == 1 || ph == 3) ? 1 : 0)) begin
        errors++; $display("FAIL enable ph %0d pop_count got %0d exp %0d", ph, pops, (ph == 1 || ph == 3) ? 1 : 0);
      end
      if (ph == 0) en = 1'b1;
      if (ph == 1) begin en = 1'b0; mq.push_back(8'h55); end
      if (ph == 2) en = 1'b1;
      drive();
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] ev;
    int pops = 0, guard = 0;
    mq.push_back(8'h96); src_on = 1'b1; en = 1'b1; drive();
    while (rem != 22 && guard < 60) begin
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if ({fifo_read, tx, busy, frame_done} !== ev) begin
        errors++;
        $display("FAIL rst_mid pre cyc %0d rd/tx/busy/done got %b exp %b", guard, {fifo_read, tx, busy, frame_done}, ev);
      end
      guard++;
      advance();
    end
    checks++;
    if (rem != 22) begin errors++; $display("FAIL rst_mid reach_bit3 got rem %0d exp 22", rem); end
    reset_n = 1'b0;
    rem = 0;
    #1;
    checks++;
    if ({fifo_read, tx, busy, frame_done} !== 4'b0100) begin
      errors++; $display("FAIL rst_mid async rd/tx/busy/done got %b exp 0100", {fifo_read, tx, busy, frame_done});
    end
    mq.push_back(8'h4B); drive();
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < ((ph == 0) ? 3 : 50); c++) begin
        @(negedge clk);
        ev = exp_vec();
        checks++;
        if ({fifo_read, tx, busy, frame_done} !== ev) begin
          errors++;
          $display("FAIL rst_mid ph %0d cyc %0d rd/tx/busy/done got %b exp %b", ph, c, {fifo_read, tx, busy, frame_done}, ev);
        end
        if (fifo_read === 1'b1) pops++;
        advance();
      end
      if (ph == 0) begin reset_n = 1'b1; drive(); end
    end
    checks++;
    if (pops !== 1) begin errors++; $display("FAIL rst_mid pop_after_release got %0d exp 1", pops); end
  endtask

  task automatic test_random();
    logic [3:0] ev;
    int n = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if ({fifo_read, tx, busy, frame_done} !== ev) begin
        errors++;
        $display("FAIL random cyc %0d rd/tx/busy/done got %b exp %b", c, {fifo_read, tx, busy, frame_done}, ev);
      end
      advance();
      if ($urandom_range(7) == 0 && mq.size() < 4) mq.push_back(8'($urandom));
      if ($urandom_range(39) == 0) en = ~en;
      if ($urandom_range(29) == 0) src_on = ~src_on;
      drive();
    end
    en = 1'b1; src_on = 1'b1; drive();
    while ((mq.size() > 0 || rem > 0) && n < 2000) begin
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if ({fifo_read, tx, busy, frame_done} !== ev) begin
        errors++;
        $display("FAIL drain cyc %0d rd/tx/busy/done got %b exp %b", n, {fifo_read, tx, busy, frame_done}, ev);
      end
      n++;
      advance();
    end
    checks++;
    if (mq.size() > 0 || rem > 0) begin
      errors++; $display("FAIL drain timeout got pending %0d exp 0", mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_parity();
    test_back_to_back();
    test_idle();
    test_enable();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
